// File: rtl/sr_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg
// Shared definitions for the SR register bank: encodings of the s=r=1
// resolution modes and the per-bit s/r next-state function used by each cell.
// ---------------------------------------------------------------------------
package sr_pkg;

    localparam int MODE_HOLD   = 0;
    localparam int MODE_SET    = 1;
    localparam int MODE_RESET  = 2;
    localparam int MODE_TOGGLE = 3;

    // Next state of one SR bit from its s/r request alone.
    // Any mode value outside the known encodings resolves s=r=1 as hold.
    function automatic logic sr_next(input logic q, input logic s,
                                     input logic r, input int mode);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            2'b11: begin
                case (mode)
                    MODE_SET:    nxt = 1'b1;
                    MODE_RESET:  nxt = 1'b0;
                    MODE_TOGGLE: nxt = ~q;
                    default:     nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// ---------------------------------------------------------------------------
// sr_cell
// One clocked SR storage bit with synchronous active-low preset_/preclear_,
// enable-gated s/r update and a sticky per-bit conflict flag.
// Ports:
//   clock, reset            - clock, async active-high reset (q <= INIT)
//   en, s, r                - enable and set/reset requests
//   preset_, preclear_      - synchronous active-low overrides
//   clr_flags               - clears the sticky conflict flag
//   q, qN                   - stored bit and its registered complement
//   conflict                - sticky: en & s & r seen
//   conflict_hit            - this cycle's en & s & r (for the bank counter)
//   illegal_hit             - this cycle's preset_=preclear_=0
// ---------------------------------------------------------------------------
module sr_cell
    import sr_pkg::*;
#(
    parameter int   MODE = MODE_HOLD,
    parameter logic INIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic preset_,
    input  logic preclear_,
    input  logic clr_flags,
    output logic q,
    output logic qN,
    output logic conflict,
    output logic conflict_hit,
    output logic illegal_hit
);

    logic q_nxt;

    assign illegal_hit  = ~preset_ & ~preclear_;
    // A conflict is recorded even when preset_/preclear_ overrides the bit.
    assign conflict_hit = en & s & r;

    always_comb begin
        q_nxt = q;
        if (illegal_hit)
            q_nxt = q;
        else if (!preset_)
            q_nxt = 1'b1;
        else if (!preclear_)
            q_nxt = 1'b0;
        else if (en)
            q_nxt = sr_next(q, s, r, MODE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q        <= INIT;
            qN       <= ~INIT;
            conflict <= 1'b0;
        end else begin
            q        <= q_nxt;
            qN       <= ~q_nxt;
            // A new event in the clearing cycle still lands in the flag.
            conflict <= clr_flags ? conflict_hit : (conflict | conflict_hit);
        end
    end

endmodule

// File: rtl/sr_register_bank.sv
// ---------------------------------------------------------------------------
// sr_register_bank
// WIDTH-bit bank of clocked SR flags sharing one clock, with a selectable
// s=r=1 resolution, sticky illegal-preset tracking and a saturating count
// of conflict cycles.
// Ports:
//   clock, reset            - clock, async active-high reset
//   en                      - gates s/r updates (preset_/preclear_ ignore it)
//   s, r                    - per-bit set/reset requests
//   preset_, preclear_      - per-bit synchronous active-low overrides
//   clr_flags               - clears conflict, ill_init and conflict_cnt
//   q, qN                   - stored value and registered complement
//   conflict                - sticky per-bit s&r conflict
//   ill_init                - sticky: some bit saw preset_=preclear_=0
//   conflict_cnt            - saturating count of cycles with any conflict
// ---------------------------------------------------------------------------
module sr_register_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               MODE  = MODE_HOLD,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
    parameter int               CW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] preset_,
    input  logic [WIDTH-1:0] preclear_,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qN,
    output logic [WIDTH-1:0] conflict,
    output logic             ill_init,
    output logic [CW-1:0]    conflict_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [WIDTH-1:0] conflict_hit;
    logic [WIDTH-1:0] illegal_hit;
    logic             any_conflict;
    logic             any_illegal;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE (MODE),
            .INIT (INIT[i])
        ) u_cell (
            .clock        (clock),
            .reset        (reset),
            .en           (en),
            .s            (s[i]),
            .r            (r[i]),
            .preset_      (preset_[i]),
            .preclear_    (preclear_[i]),
            .clr_flags    (clr_flags),
            .q            (q[i]),
            .qN           (qN[i]),
            .conflict     (conflict[i]),
            .conflict_hit (conflict_hit[i]),
            .illegal_hit  (illegal_hit[i])
        );
    end

    // The counter advances once per cycle, however many bits conflict.
    assign any_conflict = |conflict_hit;
    assign any_illegal  = |illegal_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ill_init     <= 1'b0;
            conflict_cnt <= '0;
        end else if (clr_flags) begin
            ill_init     <= any_illegal;
            conflict_cnt <= any_conflict ? {{(CW-1){1'b0}}, 1'b1} : '0;
        end else begin
            ill_init <= ill_init | any_illegal;
            if (any_conflict && conflict_cnt != CNT_MAX)
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sr_register_bank.sv
// ---------------------------------------------------------------------------
// tb_sr_register_bank
// Directed and randomised checks of sr_register_bank. Five instances share
// the same stimulus: MODE 0..3 plus an out-of-range MODE (5) that must act
// as hold.
// ---------------------------------------------------------------------------
module tb_sr_register_bank;

    localparam int NI = 5;

    logic       clock;
    logic       reset;
    logic       en;
    logic       clr_flags;
    logic [7:0] s, r, preset_, preclear_;

    logic [7:0] q_w   [NI];
    logic [7:0] qn_w  [NI];
    logic [7:0] cf_w  [NI];
    logic       ill_w [NI];
    logic [3:0] cnt_w [NI];

    int compared;
    int mismatched;

    for (genvar m = 0; m < NI; m++) begin : g_dut
        sr_register_bank #(
            .WIDTH (8),
            .MODE  ((m == 4) ? 5 : m),
            .INIT  (8'h00),
            .CW    (4)
        ) dut (
            .clock        (clock),
            .reset        (reset),
            .en           (en),
            .s            (s),
            .r            (r),
            .preset_      (preset_),
            .preclear_    (preclear_),
            .clr_flags    (clr_flags),
            .q            (q_w[m]),
            .qN           (qn_w[m]),
            .conflict     (cf_w[m]),
            .ill_init     (ill_w[m]),
            .conflict_cnt (cnt_w[m])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        en = 1'b0; clr_flags = 1'b0;
        s = 8'h00; r = 8'h00;
        preset_ = 8'hFF; preclear_ = 8'hFF;
    endtask

    task automatic pulse_reset;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic test_reset;
        for (int m = 0; m < NI; m++) begin
            compared++;
            if (q_w[m] !== 8'h00 || qn_w[m] !== 8'hFF || cf_w[m] !== 8'h00 ||
                ill_w[m] !== 1'b0 || cnt_w[m] !== 4'd0) begin
                mismatched++;
                $display("FAIL reset_state inst%0d: q=%h qN=%h cf=%h ill=%b cnt=%0d, want 00 ff 00 0 0",
                         m, q_w[m], qn_w[m], cf_w[m], ill_w[m], cnt_w[m]);
            end
        end
    endtask

    task automatic test_async_reset;
        en = 1'b1; s = 8'hFF;
        tick;
        compared++;
        if (q_w[0] !== 8'hFF) begin
            mismatched++;
            $display("FAIL pre_reset_set: q=%h want ff", q_w[0]);
        end
        #2 reset = 1'b1;
        #1;
        compared++;
        if (q_w[0] !== 8'h00 || qn_w[0] !== 8'hFF) begin
            mismatched++;
            $display("FAIL async_reset_immediate: q=%h qN=%h want 00 ff", q_w[0], qn_w[0]);
        end
        tick;
        compared++;
        if (q_w[0] !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_held: q=%h want 00", q_w[0]);
        end
        reset = 1'b0;
        tick;
        compared++;
        if (q_w[0] !== 8'hFF || qn_w[0] !== 8'h00) begin
            mismatched++;
            $display("FAIL first_edge_after_reset: q=%h qN=%h want ff 00", q_w[0], qn_w[0]);
        end
        idle_inputs();
    endtask

    task automatic test_set_reset;
        pulse_reset();
        en = 1'b1; s = 8'h0F; r = 8'h00;
        tick;
        compared++;
        if (q_w[0] !== 8'h0F || qn_w[0] !== 8'hF0) begin
            mismatched++;
            $display("FAIL set_0f: q=%h qN=%h want 0f f0", q_w[0], qn_w[0]);
        end
        s = 8'h00; r = 8'h03;
        tick;
        compared++;
        if (q_w[0] !== 8'h0C || qn_w[0] !== 8'hF3) begin
            mismatched++;
            $display("FAIL reset_03: q=%h qN=%h want 0c f3", q_w[0], qn_w[0]);
        end
        compared++;
        if (cnt_w[0] !== 4'd0) begin
            mismatched++;
            $display("FAIL no_conflict_cnt: cnt=%0d want 0", cnt_w[0]);
        end
    endtask

    task automatic test_modes;
        logic [7:0] exp1 [NI];
        logic [7:0] exp2 [NI];
        exp1 = '{8'h0C, 8'hFF, 8'h00, 8'hF3, 8'h0C};
        exp2 = '{8'h0C, 8'hFF, 8'h00, 8'h0C, 8'h0C};
        en = 1'b1; s = 8'hFF; r = 8'hFF;
        tick;
        for (int m = 0; m < NI; m++) begin
            compared++;
            if (q_w[m] !== exp1[m]) begin
                mismatched++;
                $display("FAIL mode_cycle1 inst%0d: q=%h want %h", m, q_w[m], exp1[m]);
            end
        end
        tick;
        for (int m = 0; m < NI; m++) begin
            compared++;
            if (q_w[m] !== exp2[m] || qn_w[m] !== ~exp2[m]) begin
                mismatched++;
                $display("FAIL mode_cycle2 inst%0d: q=%h qN=%h want %h", m, q_w[m], qn_w[m], exp2[m]);
            end
        end
        compared++;
        if (cf_w[3] !== 8'hFF || cnt_w[3] !== 4'd2) begin
            mismatched++;
            $display("FAIL mode_flags: cf=%h cnt=%0d want ff 2", cf_w[3], cnt_w[3]);
        end
        idle_inputs();
    endtask

    task automatic test_preset_preclear;
        // inst0 holds 0c, inst1 holds ff
        en = 1'b0; r = 8'hFF; preset_ = 8'hFE; preclear_ = 8'hFD;
        tick;
        compared++;
        if (q_w[0] !== 8'h0D || q_w[1] !== 8'hFD || ill_w[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL preset_preclear: q0=%h q1=%h ill=%b want 0d fd 0", q_w[0], q_w[1], ill_w[0]);
        end
        preset_ = 8'hFE; preclear_ = 8'hFE;
        tick;
        compared++;
        if (q_w[0] !== 8'h0D || q_w[1] !== 8'hFD || ill_w[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL illegal_preset: q0=%h q1=%h ill=%b want 0d fd 1", q_w[0], q_w[1], ill_w[0]);
        end
        idle_inputs();
    endtask

    task automatic test_saturation;
        clr_flags = 1'b1;
        tick;
        compared++;
        if (cnt_w[0] !== 4'd0 || cf_w[0] !== 8'h00 || ill_w[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL clear_flags: cnt=%0d cf=%h ill=%b want 0 00 0", cnt_w[0], cf_w[0], ill_w[0]);
        end
        clr_flags = 1'b0;
        en = 1'b1; s = 8'h01; r = 8'h01;
        for (int i = 1; i <= 20; i++) begin
            tick;
            compared++;
            if (cnt_w[0] !== 4'((i > 15) ? 15 : i)) begin
                mismatched++;
                $display("FAIL cnt_sat step%0d: cnt=%0d want %0d", i, cnt_w[0], (i > 15) ? 15 : i);
            end
        end
        clr_flags = 1'b1; s = 8'h30; r = 8'h30;
        tick;
        compared++;
        if (cnt_w[0] !== 4'd1 || cf_w[0] !== 8'h30) begin
            mismatched++;
            $display("FAIL clear_with_event: cnt=%0d cf=%h want 1 30", cnt_w[0], cf_w[0]);
        end
        s = 8'h00; r = 8'h00;
        tick;
        compared++;
        if (cnt_w[0] !== 4'd0 || cf_w[0] !== 8'h00) begin
            mismatched++;
            $display("FAIL clear_no_event: cnt=%0d cf=%h want 0 00", cnt_w[0], cf_w[0]);
        end
        clr_flags = 1'b0;
        pulse_reset();
        en = 1'b1; s = 8'h80; r = 8'h80; preset_ = 8'h7F;
        tick;
        compared++;
        if (cf_w[2] !== 8'h80 || q_w[2] !== 8'h80 || cnt_w[2] !== 4'd1) begin
            mismatched++;
            $display("FAIL conflict_under_preset: cf=%h q=%h cnt=%0d want 80 80 1", cf_w[2], q_w[2], cnt_w[2]);
        end
        idle_inputs();
    endtask

    task automatic test_random;
        logic [7:0] mq [NI];
        logic [7:0] mcf;
        logic       mill;
        logic [3:0] mcnt;
        logic [7:0] hit;
        int         errs;
        errs = 0;
        pulse_reset();
        for (int m = 0; m < NI; m++) mq[m] = 8'h00;
        mcf = 8'h00; mill = 1'b0; mcnt = 4'd0;
        for (int c = 0; c < 10000; c++) begin
            en        = ($urandom_range(3) != 0);
            clr_flags = ($urandom_range(15) == 0);
            s         = 8'($urandom);
            r         = 8'($urandom);
            preset_   = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
            preclear_ = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
            tick;
            for (int m = 0; m < NI; m++) begin
                for (int b = 0; b < 8; b++) begin
                    if (!preset_[b] && !preclear_[b])  mq[m][b] = mq[m][b];
                    else if (!preset_[b])              mq[m][b] = 1'b1;
                    else if (!preclear_[b])            mq[m][b] = 1'b0;
                    else if (!en)                      mq[m][b] = mq[m][b];
                    else if (s[b] && !r[b])            mq[m][b] = 1'b1;
                    else if (!s[b] && r[b])            mq[m][b] = 1'b0;
                    else if (s[b] && r[b]) begin
                        if (m == 1)      mq[m][b] = 1'b1;
                        else if (m == 2) mq[m][b] = 1'b0;
                        else if (m == 3) mq[m][b] = ~mq[m][b];
                    end
                end
            end
            hit = en ? (s & r) : 8'h00;
            if (clr_flags) begin
                mcf  = hit;
                mill = |(~preset_ & ~preclear_);
                mcnt = (hit != 0) ? 4'd1 : 4'd0;
            end else begin
                mcf  = mcf | hit;
                mill = mill | (|(~preset_ & ~preclear_));
                if (hit != 0 && mcnt != 4'd15) mcnt = mcnt + 4'd1;
            end
            for (int m = 0; m < NI; m++) begin
                compared++;
                if (q_w[m] !== mq[m] || qn_w[m] !== ~q_w[m]) begin
                    mismatched++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL random_q cyc%0d inst%0d: q=%h qN=%h want %h", c, m, q_w[m], qn_w[m], mq[m]);
                end
            end
            compared++;
            if (cf_w[0] !== mcf || ill_w[0] !== mill || cnt_w[0] !== mcnt) begin
                mismatched++;
                errs++;
                if (errs < 10)
                    $display("FAIL random_flags cyc%0d: cf=%h ill=%b cnt=%0d want %h %b %0d",
                             c, cf_w[0], ill_w[0], cnt_w[0], mcf, mill, mcnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        idle_inputs();
        tick;
        tick;
        test_reset();
        reset = 1'b0;
        test_async_reset();
        test_set_reset();
        test_modes();
        test_preset_preclear();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
